// File: rtl/conv_pkg.sv
// conv_pkg
// Shared definitions for the convolution engine and its stream transmitter:
//   - tx_state_t      : transmitter FSM states (IDLE, FETCH, SEND, DONE)
//   - CONV_DATA_WIDTH : default sample width in bits
//   - CONV_X_SIZE     : default samples per x frame
package conv_pkg;

  localparam int CONV_DATA_WIDTH = 8;
  localparam int CONV_X_SIZE     = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/tx_frame_ram.sv
// tx_frame_ram
// One-write / one-read frame buffer, X_SIZE x DATA_WIDTH, synchronous read.
// The storage array is not reset; only the read data register is, so the
// stream data output starts from zero after reset.
// Ports:
//   clk, reset            : clock, synchronous active-high reset (read register only)
//   wr_en/wr_addr/wr_data : write port
//   rd_en/rd_addr         : read request; rd_data updates on the next edge
//   rd_data               : registered read data, held while rd_en is low
module tx_frame_ram
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = CONV_DATA_WIDTH,
  parameter int X_SIZE     = CONV_X_SIZE,
  parameter int ADDR_WIDTH = $clog2(X_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [X_SIZE];

  // write port: storage array deliberately has no reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // read port: registered output, held when no read is requested
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= rd_data;
    end
  end

endmodule

// File: rtl/conv_x_stream_tx.sv
// conv_x_stream_tx
// Master-side valid/ready transmitter feeding the convolution engine's x port.
// The host fills a frame buffer, pulses host_start, and the block streams
// X_SIZE samples in address order at up to one beat per cycle.
// Optional feature: define CONV_TX_LAST_EN to add the m_last output.
// Ports:
//   clk, reset                        : clock, synchronous active-high reset
//   host_wr_en/host_wr_addr/host_wr_data : frame buffer write (accepted in IDLE only)
//   host_start                        : start pulse (ignored unless IDLE)
//   host_busy                         : high from accepted start until tx_done
//   host_wr_err                       : pulse one cycle after a dropped write
//   m_data/m_valid/m_ready            : stream handshake (master side)
//   m_last                            : final-beat flag (CONV_TX_LAST_EN only)
//   tx_done                           : one-cycle pulse after the last beat
//   frame_cnt                         : completed frames, wraps 255 -> 0
module conv_x_stream_tx
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = CONV_DATA_WIDTH,
  parameter int X_SIZE     = CONV_X_SIZE,
  parameter int ADDR_WIDTH = $clog2(X_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  host_wr_en,
  input  logic [ADDR_WIDTH-1:0] host_wr_addr,
  input  logic [DATA_WIDTH-1:0] host_wr_data,
  input  logic                  host_start,
  output logic                  host_busy,
  output logic                  host_wr_err,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
`ifdef CONV_TX_LAST_EN
  output logic                  m_last,
`endif
  output logic                  tx_done,
  output logic [7:0]            frame_cnt
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(X_SIZE - 1);

  tx_state_t             state;
  tx_state_t             next_state;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr_next;
  logic                  ram_wr_en;
  logic                  ram_rd_en;
  logic [ADDR_WIDTH-1:0] ram_rd_addr;
  logic                  handshake;
  logic                  at_last;

  // m_valid is only ever high in SEND, so the handshake needs no m_valid term
  assign handshake = (state == SEND) && m_ready;
  assign at_last   = (rd_ptr == LAST_ADDR);
  assign ram_wr_en = host_wr_en && (state == IDLE);

  // The RAM read register is the prefetch stage and directly drives m_data:
  // it is re-read with the next address on each handshake and left untouched
  // while stalled, which keeps m_data stable under backpressure.
  tx_frame_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .X_SIZE     (X_SIZE),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (ram_wr_en),
    .wr_addr (host_wr_addr),
    .wr_data (host_wr_data),
    .rd_en   (ram_rd_en),
    .rd_addr (ram_rd_addr),
    .rd_data (m_data)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (host_start) begin
          next_state = FETCH;
        end else begin
          next_state = IDLE;
        end
      end
      FETCH: begin
        next_state = SEND;
      end
      SEND: begin
        if (handshake && at_last) begin
          next_state = DONE;
        end else begin
          next_state = SEND;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // FSM output logic: buffer read requests and next read pointer
  always_comb begin
    rd_ptr_next = rd_ptr;
    ram_rd_en   = 1'b0;
    ram_rd_addr = rd_ptr;
    case (state)
      IDLE: begin
        if (host_start) begin
          rd_ptr_next = '0;
        end else begin
          rd_ptr_next = rd_ptr;
        end
      end
      FETCH: begin
        ram_rd_en   = 1'b1;
        ram_rd_addr = '0;
      end
      SEND: begin
        // no fetch after the final beat: the pointer never wraps in a frame
        if (handshake && !at_last) begin
          rd_ptr_next = rd_ptr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
          ram_rd_en   = 1'b1;
          ram_rd_addr = rd_ptr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end else begin
          rd_ptr_next = rd_ptr;
          ram_rd_en   = 1'b0;
        end
      end
      DONE: begin
        rd_ptr_next = rd_ptr;
      end
      default: begin
        rd_ptr_next = '0;
      end
    endcase
  end

  // registered status outputs, all derived from the state being entered
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr      <= '0;
      m_valid     <= 1'b0;
      host_busy   <= 1'b0;
      tx_done     <= 1'b0;
      host_wr_err <= 1'b0;
      frame_cnt   <= 8'd0;
    end else begin
      rd_ptr      <= rd_ptr_next;
      m_valid     <= (next_state == SEND);
      host_busy   <= (next_state != IDLE);
      tx_done     <= (next_state == DONE);
      host_wr_err <= host_wr_en && (state != IDLE);
      if (next_state == DONE) begin
        frame_cnt <= frame_cnt + 8'd1;
      end else begin
        frame_cnt <= frame_cnt;
      end
    end
  end

`ifdef CONV_TX_LAST_EN
  // last-beat flag tracks the pointer of the beat being presented next cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      m_last <= 1'b0;
    end else begin
      m_last <= (next_state == SEND) && (rd_ptr_next == LAST_ADDR);
    end
  end
`endif

endmodule

// File: tb/tb_conv_x_stream_tx.sv
// tb_conv_x_stream_tx
// Directed self-checking bench for conv_x_stream_tx (DATA_WIDTH=8, X_SIZE=128).
// Define CONV_TX_LAST_EN on the command line to also check m_last.
module tb_conv_x_stream_tx;

  localparam int DW = 8;
  localparam int XS = 128;
  localparam int AW = 7;

  logic          clk;
  logic          reset;
  logic          host_wr_en;
  logic [AW-1:0] host_wr_addr;
  logic [DW-1:0] host_wr_data;
  logic          host_start;
  logic          host_busy;
  logic          host_wr_err;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
`ifdef CONV_TX_LAST_EN
  logic          m_last;
`endif
  logic          tx_done;
  logic [7:0]    frame_cnt;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] mem [XS];

  conv_x_stream_tx #(
    .DATA_WIDTH (DW),
    .X_SIZE     (XS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .host_wr_en   (host_wr_en),
    .host_wr_addr (host_wr_addr),
    .host_wr_data (host_wr_data),
    .host_start   (host_start),
    .host_busy    (host_busy),
    .host_wr_err  (host_wr_err),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
`ifdef CONV_TX_LAST_EN
    .m_last       (m_last),
`endif
    .tx_done      (tx_done),
    .frame_cnt    (frame_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start a frame with m_ready held high and check every beat cycle-exactly.
  // bad_beat >= 0: on that beat write addr 5 = 0xAA and pulse start (both must be ignored).
  // wr_on_start: write addr 7 = 0x77 together with the start (must be transmitted).
  task automatic send_frame(input int bad_beat, input bit wr_on_start, input logic [7:0] exp_cnt);
    m_ready    = 1'b1;
    host_start = 1'b1;
    if (wr_on_start) begin
      host_wr_en   = 1'b1;
      host_wr_addr = 7'd7;
      host_wr_data = 8'h77;
      mem[7]       = 8'h77;
    end
    tick();  // T+1
    host_start = 1'b0;
    host_wr_en = 1'b0;
    check("busy_t1", 32'(host_busy), 32'd1);
    check("valid_t1", 32'(m_valid), 32'd0);
    check("wr_err_t1", 32'(host_wr_err), 32'd0);
    for (int k = 0; k < XS; k++) begin
      tick();  // T+2+k
      host_start = 1'b0;
      host_wr_en = 1'b0;
      check("beat_wr_err", 32'(host_wr_err), 32'((bad_beat >= 0) && (k == bad_beat + 1)));
      check("beat_valid", 32'(m_valid), 32'd1);
      check("beat_data", 32'(m_data), 32'(mem[k]));
`ifdef CONV_TX_LAST_EN
      check("beat_last", 32'(m_last), 32'(k == XS - 1));
`endif
      if (k == bad_beat) begin
        host_wr_en   = 1'b1;
        host_wr_addr = 7'd5;
        host_wr_data = 8'hAA;
        host_start   = 1'b1;
      end
    end
    tick();  // T+2+XS
    check("done_pulse", 32'(tx_done), 32'd1);
    check("done_cnt", 32'(frame_cnt), 32'(exp_cnt));
    check("done_valid", 32'(m_valid), 32'd0);
    check("done_busy", 32'(host_busy), 32'd1);
    tick();  // T+3+XS
    check("idle_busy", 32'(host_busy), 32'd0);
    check("idle_done", 32'(tx_done), 32'd0);
    check("idle_valid", 32'(m_valid), 32'd0);
  endtask

  initial begin
    logic [DW-1:0] hold_data;
    bit            hold_pending;
    bit            done_seen;
    int            idx;

    reset        = 1'b1;
    host_wr_en   = 1'b0;
    host_wr_addr = '0;
    host_wr_data = '0;
    host_start   = 1'b0;
    m_ready      = 1'b0;

    // reset values
    tick();
    tick();
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    check("rst_busy", 32'(host_busy), 32'd0);
    check("rst_wr_err", 32'(host_wr_err), 32'd0);
    check("rst_cnt", 32'(frame_cnt), 32'd0);
`ifdef CONV_TX_LAST_EN
    check("rst_last", 32'(m_last), 32'd0);
`endif
    reset = 1'b0;

    // load samples 0..127 while idle
    for (int i = 0; i < XS; i++) begin
      host_wr_en   = 1'b1;
      host_wr_addr = AW'(i);
      host_wr_data = DW'(i);
      mem[i]       = DW'(i);
      tick();
      check("load_wr_err", 32'(host_wr_err), 32'd0);
    end
    host_wr_en = 1'b0;
    tick();

    // full throughput
    send_frame(-1, 1'b0, 8'd1);

    // backpressure with random m_ready
    m_ready      = 1'b0;
    host_start   = 1'b1;
    tick();
    host_start   = 1'b0;
    idx          = 0;
    hold_pending = 1'b0;
    hold_data    = '0;
    done_seen    = 1'b0;
    for (int c = 0; c < 2000 && !done_seen; c++) begin
      tick();
      if (tx_done) begin
        done_seen = 1'b1;
      end else begin
        if (hold_pending) begin
          check("bp_hold_valid", 32'(m_valid), 32'd1);
          check("bp_hold_data", 32'(m_data), 32'(hold_data));
        end
        m_ready = 1'($urandom_range(0, 1));
        if (m_valid && m_ready) begin
          check("bp_data", 32'(m_data), 32'(mem[idx % XS]));
          idx++;
          hold_pending = 1'b0;
        end else if (m_valid) begin
          hold_pending = 1'b1;
          hold_data    = m_data;
        end else begin
          hold_pending = 1'b0;
        end
      end
    end
    check("bp_done_seen", 32'(done_seen), 32'd1);
    check("bp_count", 32'(idx), 32'(XS));
    check("bp_cnt", 32'(frame_cnt), 32'd2);
    m_ready = 1'b1;
    tick();
    check("bp_idle_busy", 32'(host_busy), 32'd0);

    // illegal write and start during SEND; then retransmit untouched buffer
    send_frame(10, 1'b0, 8'd3);
    tick();
    check("ignored_start_busy", 32'(host_busy), 32'd0);
    check("ignored_start_valid", 32'(m_valid), 32'd0);
    send_frame(-1, 1'b0, 8'd4);

    // reset after beat 40
    host_start = 1'b1;
    m_ready    = 1'b1;
    tick();
    host_start = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      tick();
      check("pre_rst_data", 32'(m_data), 32'(mem[k]));
    end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_valid", 32'(m_valid), 32'd0);
    check("midrst_cnt", 32'(frame_cnt), 32'd0);
    check("midrst_busy", 32'(host_busy), 32'd0);
    check("midrst_done", 32'(tx_done), 32'd0);

    // restart from word 0 with the buffer intact, plus a write alongside start
    send_frame(-1, 1'b1, 8'd1);

    // back-to-back frames until the counter wraps to 0
    for (int n = 2; n <= 256; n++) begin
      send_frame(-1, 1'b0, 8'(n));
    end
    check("wrap_cnt", 32'(frame_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
